// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU format defaults, derived widths and sequencer state
package fpu_pkg;

    localparam int FPU_NEXP = 8;
    localparam int FPU_NSIG = 7;
    localparam int FPU_W    = FPU_NSIG + 1;
    localparam int FPU_PW   = 2 * FPU_NSIG + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/sig_mult_seq.sv
// rtl/sig_mult_seq.sv - iterative shift-and-add significand multiplier producing pSig
// Optional early exit on an exhausted multiplier: define SIG_MULT_EARLY_EXIT_EN
module sig_mult_seq
    import fpu_pkg::*;
#(
    parameter int NEXP = FPU_NEXP,
    parameter int NSIG = FPU_NSIG
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NSIG:0]       a_sig,
    input  logic [NSIG:0]       b_sig,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*NSIG+1:0]   pSig,
    output logic                norm_hi
);

    localparam int W  = NSIG + 1;
    localparam int PW = 2 * W;
    localparam int CW = cnt_width(W);

    // NEXP only keeps the parameter list uniform across the FPU units.
    if (NEXP > 0) begin : g_nexp_carried
    end

    seq_state_t         r_state;
    logic [W-1:0]       r_a;
    logic [PW:0]        r_p;
    logic [CW-1:0]      r_cnt;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [PW-1:0]      r_psig;
    logic               r_norm_hi;

    logic [W:0]         w_sum;
    logic [PW-1:0]      w_p_next;
    logic [PW-1:0]      w_p_final;
    logic               w_last;
    logic               w_finish;

    // Upper half plus carry accumulates; the multiplier drains out of the low half.
    assign w_sum    = r_p[PW:W] + (r_p[0] ? {1'b0, r_a} : '0);
    assign w_p_next = {w_sum, r_p[W-1:1]};
    assign w_last   = (r_cnt == CW'(W - 1));

`ifdef SIG_MULT_EARLY_EXIT_EN
    logic [CW-1:0]      w_rem;
    logic [W-1:0]       w_mask;
    logic               w_early;

    // Remaining steps would only add zero, so a single shift finishes the product.
    assign w_rem     = CW'(W - 1) - r_cnt;
    assign w_mask    = ~({W{1'b1}} << w_rem);
    assign w_early   = ((w_p_next[W-1:0] & w_mask) == '0);
    assign w_finish  = w_last | w_early;
    assign w_p_final = w_p_next >> w_rem;
`else
    assign w_finish  = w_last;
    assign w_p_final = w_p_next;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_p         <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_psig      <= '0;
            r_norm_hi   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a        <= a_sig;
                        r_p        <= {(W + 1)'(0), b_sig};
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= BUSY;
                    end
                end
                BUSY: begin
                    r_p   <= {1'b0, w_p_next};
                    r_cnt <= r_cnt + CW'(1);
                    if (w_finish) begin
                        r_psig      <= w_p_final;
                        r_norm_hi   <= w_p_final[PW-1];
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign pSig      = r_psig;
    assign norm_hi   = r_norm_hi;

endmodule

// File: tb/tb_sig_mult_seq.sv
// tb/tb_sig_mult_seq.sv - directed and random checks of sig_mult_seq (bfloat16 significands)
module tb_sig_mult_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a_sig;
    logic [7:0]  b_sig;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] pSig;
    logic        norm_hi;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sig_mult_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_sig     (a_sig),
        .b_sig     (b_sig),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pSig      (pSig),
        .norm_hi   (norm_hi)
    );

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
        logic        n;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Cycles from the accept cycle (index 0) to the first cycle showing out_valid.
    function automatic int exp_lat(input logic [7:0] b);
`ifdef SIG_MULT_EARLY_EXIT_EN
        int steps = 1;
        for (int i = 0; i < 8; i++) if (b[i]) steps = i + 1;
        return steps + 1;
`else
        return 9;
`endif
    endfunction

    task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                         output logic [15:0] p, output logic n, output int lat);
        @(negedge clk);
        a_sig    = a;
        b_sig    = b;
        in_valid = 1'b1;
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        p = pSig;
        n = norm_hi;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] p;
        logic        n;
        int          lat;
        int          acc_cyc[2];
        int          n_acc;
        int          saw_valid;

        vecs[0]  = '{8'h80, 8'h80, 16'h4000, 1'b0};
        vecs[1]  = '{8'hFF, 8'hFF, 16'hFE01, 1'b1};
        vecs[2]  = '{8'hC0, 8'hC0, 16'h9000, 1'b1};
        vecs[3]  = '{8'h81, 8'h80, 16'h4080, 1'b0};
        vecs[4]  = '{8'h00, 8'hA5, 16'h0000, 1'b0};
        vecs[5]  = '{8'h80, 8'h01, 16'h0080, 1'b0};
        vecs[6]  = '{8'hA5, 8'h5A, 16'h3A02, 1'b0};
        vecs[7]  = '{8'hFF, 8'h80, 16'h7F80, 1'b0};
        vecs[8]  = '{8'h80, 8'hFF, 16'h7F80, 1'b0};
        vecs[9]  = '{8'hFF, 8'h01, 16'h00FF, 1'b0};
        vecs[10] = '{8'h01, 8'h01, 16'h0001, 1'b0};
        vecs[11] = '{8'hAA, 8'h55, 16'h3872, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a_sig = '0; b_sig = '0;
        repeat (2) @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_psig", 32'(pSig), 32'd0);
        chk("reset_norm_hi", 32'(norm_hi), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            do_op(vecs[i].a, vecs[i].b, p, n, lat);
            chk($sformatf("vec%0d_psig", i), 32'(p), 32'(vecs[i].p));
            chk($sformatf("vec%0d_norm_hi", i), 32'(n), 32'(vecs[i].n));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(exp_lat(vecs[i].b)));
        end
        @(negedge clk);
        chk("out_valid_drops_after_handshake", 32'(out_valid), 32'd0);

        // Backpressure: hold the product for 5 cycles while a second request waits.
        out_ready = 1'b0;
        do_op(8'hC0, 8'hC0, p, n, lat);
        chk("bp_psig", 32'(p), 32'h9000);
        a_sig = 8'hFF; b_sig = 8'hFF; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp%0d_out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("bp%0d_psig", i), 32'(pSig), 32'h9000);
            chk($sformatf("bp%0d_norm_hi", i), 32'(norm_hi), 32'd1);
            chk($sformatf("bp%0d_in_ready", i), 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        chk("bp_handshake_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("bp_after_out_valid", 32'(out_valid), 32'd0);
        chk("bp_after_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_second_accepted", 32'(in_ready), 32'd0);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("bp_second_psig", 32'(pSig), 32'hFE01);
        chk("bp_second_latency", 32'(lat), 32'(exp_lat(8'hFF)));

        // Throughput with in_valid and out_ready held high.
        @(negedge clk);
        a_sig = 8'h80; b_sig = 8'h80; in_valid = 1'b1;
        n_acc = 0;
        for (int c = 0; c < 40 && n_acc < 2; c++) begin
            if (in_valid && in_ready) begin
                acc_cyc[n_acc] = c;
                n_acc++;
            end
            if (n_acc < 2) @(negedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("throughput_accepts", 32'(n_acc), 32'd2);
        if (n_acc == 2) chk("throughput_period", 32'(acc_cyc[1] - acc_cyc[0]), 32'd10);
        repeat (12) @(negedge clk);
        chk("throughput_psig", 32'(pSig), 32'h4000);

        // Asynchronous reset during BUSY cycle 4 aborts the product.
        @(negedge clk);
        a_sig = 8'hFF; b_sig = 8'hFF; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd1);
        chk("async_rst_psig", 32'(pSig), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1;
        end
        chk("aborted_no_output", 32'(saw_valid), 32'd0);
        do_op(8'h81, 8'h80, p, n, lat);
        chk("post_reset_psig", 32'(p), 32'h4080);
        chk("post_reset_latency", 32'(lat), 32'd9);

        for (int i = 0; i < 1000; i++) begin
            logic [7:0]  ra;
            logic [7:0]  rb;
            logic [15:0] ref_p;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            ref_p = 16'(ra) * 16'(rb);
            do_op(ra, rb, p, n, lat);
            chk($sformatf("rand%0d_psig_%0h_%0h", i, ra, rb), 32'(p), 32'(ref_p));
            chk($sformatf("rand%0d_latency", i), 32'(lat), 32'(exp_lat(rb)));
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
